// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-stage definitions: widths, free-list pointer type and popcount.
//   DECODE_WIDTH / COMMIT_WIDTH : rename and commit slot counts
//   FL_PHY_REG_NUM / FL_PW      : physical register count and preg index width
//   fl_ptr_t                    : free-list pointer (index plus wrap bit)
//   popcount()                  : number of set bits in a request vector
package phys_reg_free_list_pkg;

  localparam int unsigned DECODE_WIDTH   = 4;
  localparam int unsigned COMMIT_WIDTH   = 2;
  localparam int unsigned FL_PHY_REG_NUM = 64;
  localparam int unsigned FL_PW          = $clog2(FL_PHY_REG_NUM);

  // Upper bound on vectors handed to popcount(); callers zero-extend.
  localparam int unsigned POPCNT_MAX_W = 16;
  localparam int unsigned POPCNT_CW    = $clog2(POPCNT_MAX_W + 1);

  typedef logic [FL_PW:0] fl_ptr_t;

  function automatic logic [POPCNT_CW-1:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
    logic [POPCNT_CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(POPCNT_MAX_W); i++) begin
      cnt = cnt + POPCNT_CW'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit/flush bus between the pipeline and the physical register free list.
//   alloc_req_i / alloc_ready_o / alloc_preg_o : per-slot allocation
//   commit_dest_i                               : committed dests (arch head advance)
//   free_i / free_preg_i                        : released pregs
//   restore_i                                   : flush rewind
//   free_cnt_o                                  : speculative free count
//   err_o                                       : sticky consistency error (FREELIST_CHECK_EN only)
interface phys_reg_free_list_if
  import phys_reg_free_list_pkg::*;
#(
  parameter int unsigned PHY_REG_NUM = FL_PHY_REG_NUM
);

  localparam int unsigned PW = $clog2(PHY_REG_NUM);

  logic [DECODE_WIDTH-1:0]          alloc_req_i;
  logic                             alloc_ready_o;
  logic [DECODE_WIDTH-1:0][PW-1:0]  alloc_preg_o;
  logic [COMMIT_WIDTH-1:0]          commit_dest_i;
  logic [COMMIT_WIDTH-1:0]          free_i;
  logic [COMMIT_WIDTH-1:0][PW-1:0]  free_preg_i;
  logic                             restore_i;
  logic [PW:0]                      free_cnt_o;
`ifdef FREELIST_CHECK_EN
  logic                             err_o;
`endif

  modport master (
    output alloc_req_i, commit_dest_i, free_i, free_preg_i, restore_i,
`ifdef FREELIST_CHECK_EN
    input  err_o,
`endif
    input  alloc_ready_o, alloc_preg_o, free_cnt_o
  );

  modport slave (
    input  alloc_req_i, commit_dest_i, free_i, free_preg_i, restore_i,
`ifdef FREELIST_CHECK_EN
    output err_o,
`endif
    output alloc_ready_o, alloc_preg_o, free_cnt_o
  );

endinterface

// File: rtl/phys_reg_free_list_prefix_popcount.sv
// Exclusive prefix popcount of a request vector.
//   i_req    : request bits
//   o_prefix : per-bit count of set bits strictly below it
//   o_total  : total set bits
module prefix_popcount #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]                      i_req,
  output logic [W-1:0][$clog2(W+1)-1:0]     o_prefix,
  output logic [$clog2(W+1)-1:0]            o_total
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [CW-1:0] w_acc;

  // Running sum; each bit sees the count before it is added.
  always_comb begin
    w_acc    = '0;
    o_prefix = '0;
    for (int i = 0; i < int'(W); i++) begin
      o_prefix[i] = w_acc;
      w_acc       = w_acc + CW'(i_req[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular FIFO of free preg numbers with a
// speculative head (rename), an architectural head (commit) and a tail (free).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : phys_reg_free_list_if.slave (alloc / commit / free / restore / count)
// Optional: define FREELIST_CHECK_EN to add the sticky err_o consistency check.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int unsigned PHY_REG_NUM = FL_PHY_REG_NUM
) (
  input  logic                    clk,
  input  logic                    rst_n,
  phys_reg_free_list_if.slave     bus
);

  localparam int unsigned PW  = $clog2(PHY_REG_NUM);
  localparam int unsigned DCW = $clog2(DECODE_WIDTH + 1);
  localparam int unsigned CCW = $clog2(COMMIT_WIDTH + 1);

  logic [PW-1:0] r_fl_q [PHY_REG_NUM];
  logic [PW:0]   r_spec_head;
  logic [PW:0]   r_arch_head;
  logic [PW:0]   r_tail;

  logic [DECODE_WIDTH-1:0][DCW-1:0] w_alloc_off;
  logic [DCW-1:0]                   w_alloc_cnt;
  logic [COMMIT_WIDTH-1:0][CCW-1:0] w_free_off;
  logic [CCW-1:0]                   w_free_total;

  logic [PW:0]   w_free_cnt;
  logic [PW:0]   w_commit_cnt;
  logic          w_ready;
  logic          w_fire;
  logic [PW:0]   w_spec_nxt;
  logic [PW:0]   w_arch_nxt;
  logic [PW:0]   w_tail_nxt;

  logic [PW-1:0] w_rd_idx [DECODE_WIDTH];
  logic [PW-1:0] w_wr_idx [COMMIT_WIDTH];
  logic [DECODE_WIDTH-1:0][PW-1:0] w_alloc_preg;

  prefix_popcount #(.W(DECODE_WIDTH)) u_alloc_pfx (
    .i_req    (bus.alloc_req_i),
    .o_prefix (w_alloc_off),
    .o_total  (w_alloc_cnt)
  );

  prefix_popcount #(.W(COMMIT_WIDTH)) u_free_pfx (
    .i_req    (bus.free_i),
    .o_prefix (w_free_off),
    .o_total  (w_free_total)
  );

  assign w_commit_cnt = (PW+1)'(popcount(POPCNT_MAX_W'(bus.commit_dest_i)));
  assign w_free_cnt   = r_tail - r_spec_head;

  // All-or-nothing grant; a flush cycle never allocates.
  assign w_ready = ((PW+1)'(w_alloc_cnt) <= w_free_cnt) && !bus.restore_i;
  assign w_fire  = w_ready && (|bus.alloc_req_i);

  assign w_arch_nxt = r_arch_head + w_commit_cnt;
  assign w_tail_nxt = r_tail + (PW+1)'(w_free_total);

  // Restore rewinds to the arch head including this cycle's commits.
  always_comb begin
    w_spec_nxt = r_spec_head;
    if (bus.restore_i) begin
      w_spec_nxt = w_arch_nxt;
    end else if (w_fire) begin
      w_spec_nxt = r_spec_head + (PW+1)'(w_alloc_cnt);
    end
  end

  // Read ports: compacted slots index consecutive entries from the spec head.
  always_comb begin
    for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
      w_rd_idx[i]     = r_spec_head[PW-1:0] + PW'(w_alloc_off[i]);
      w_alloc_preg[i] = bus.alloc_req_i[i] ? r_fl_q[w_rd_idx[i]] : '0;
    end
  end

  // Write ports: compacted frees land on consecutive entries from the tail.
  always_comb begin
    for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
      w_wr_idx[k] = r_tail[PW-1:0] + PW'(w_free_off[k]);
    end
  end

  // Storage and pointers; entry k resets to k+1, which wraps the last to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(PHY_REG_NUM); k++) begin
        r_fl_q[k] <= PW'(k + 1);
      end
      r_spec_head <= '0;
      r_arch_head <= '0;
      r_tail      <= (PW+1)'(PHY_REG_NUM - 1);
    end else begin
      for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
        if (bus.free_i[k]) begin
          r_fl_q[w_wr_idx[k]] <= bus.free_preg_i[k];
        end
      end
      r_spec_head <= w_spec_nxt;
      r_arch_head <= w_arch_nxt;
      r_tail      <= w_tail_nxt;
    end
  end

  assign bus.alloc_ready_o = w_ready;
  assign bus.alloc_preg_o  = w_alloc_preg;
  assign bus.free_cnt_o    = w_free_cnt;

`ifdef FREELIST_CHECK_EN
  logic        r_err;
  logic [PW:0] w_fl_span;
  logic [PW:0] w_spec_lead;
  logic        w_free_zero;
  logic        w_err_set;

  assign w_fl_span   = w_tail_nxt - w_arch_nxt;
  assign w_spec_lead = w_spec_nxt - w_arch_nxt;

  always_comb begin
    w_free_zero = 1'b0;
    for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
      if (bus.free_i[k] && (bus.free_preg_i[k] == '0)) begin
        w_free_zero = 1'b1;
      end
    end
  end

  // A span with the wrap bit set means the distance went beyond PHY_REG_NUM-1.
  assign w_err_set = ((|bus.free_i) && w_fl_span[PW]) || w_free_zero || w_spec_lead[PW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed vector table, then randomized traffic
// checked against a queue-based model of the free list.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  phys_reg_free_list_if bus_if ();

  phys_reg_free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    int         rep;
    logic [3:0] req;
    logic [1:0] cm;
    logic [1:0] fr;
    logic [5:0] fp0;
    logic [5:0] fp1;
    logic       rs;
    logic       exp_ready;
    logic [5:0] ep [4];
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input int rep, input logic [3:0] req,
                              input logic [1:0] cm, input logic [1:0] fr, input int fp0,
                              input int fp1, input logic rs, input logic er, input int p0,
                              input int p1, input int p2, input int p3, input int cnt);
    vec_t v;
    v.rst = rst; v.rep = rep; v.req = req; v.cm = cm; v.fr = fr;
    v.fp0 = 6'(fp0); v.fp1 = 6'(fp1); v.rs = rs; v.exp_ready = er;
    v.ep[0] = 6'(p0); v.ep[1] = 6'(p1); v.ep[2] = 6'(p2); v.ep[3] = 6'(p3);
    v.exp_cnt = cnt;
    return v;
  endfunction

  function automatic int pc(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic chk(input string name, input int idx, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [1:0] cm, input logic [1:0] fr,
                       input logic [5:0] fp0, input logic [5:0] fp1, input logic rs);
    bus_if.alloc_req_i    = req;
    bus_if.commit_dest_i  = cm;
    bus_if.free_i         = fr;
    bus_if.free_preg_i[0] = fp0;
    bus_if.free_preg_i[1] = fp1;
    bus_if.restore_i      = rs;
  endtask

  task automatic do_reset();
    drive(4'b0, 2'b0, 2'b0, 6'd0, 6'd0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    if (v.rst) do_reset();
    for (int r = 0; r < v.rep; r++) begin
      drive(v.req, v.cm, v.fr, v.fp0, v.fp1, v.rs);
      @(negedge clk);
      if (r == v.rep - 1) begin
        chk("ready", idx, int'(bus_if.alloc_ready_o), int'(v.exp_ready));
        chk("free_cnt", idx, int'(bus_if.free_cnt_o), v.exp_cnt);
        for (int s = 0; s < 4; s++) begin
          chk($sformatf("preg_slot%0d", s), idx, int'(bus_if.alloc_preg_o[s]), int'(v.ep[s]));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Model: fl holds entries from arch head to tail; spec_n of them are
  // speculatively handed out; released holds committed-away old pregs.
  int fl[$];
  int released[$];
  int spec_n;

  task automatic random_phase(input int cycles);
    logic [3:0] req;
    logic [1:0] cm, fr;
    logic [5:0] fp0, fp1;
    logic       rs;
    int k, off, exp_cnt, c, f;
    logic exp_ready;
    do_reset();
    fl.delete(); released.delete(); spec_n = 0;
    for (int p = 1; p < 64; p++) fl.push_back(p);
    for (int cyc = 0; cyc < cycles; cyc++) begin
      req = 4'($urandom_range(0, 15));
      rs  = ($urandom_range(0, 15) == 0);
      cm  = 2'($urandom_range(0, 3));
      if (pc({2'b0, cm}) > spec_n) cm = (spec_n >= 1) ? 2'b01 : 2'b00;
      fr  = 2'($urandom_range(0, 3));
      if (pc({2'b0, fr}) > released.size()) fr = (released.size() >= 1) ? 2'b01 : 2'b00;
      fp0 = 6'($urandom_range(1, 63));
      fp1 = 6'($urandom_range(1, 63));
      f = 0;
      if (fr[0]) begin fp0 = 6'(released[f]); f++; end
      if (fr[1]) begin fp1 = 6'(released[f]); f++; end
      drive(req, cm, fr, fp0, fp1, rs);

      k         = pc(req);
      exp_cnt   = fl.size() - spec_n;
      exp_ready = (k <= exp_cnt) && !rs;
      @(negedge clk);
      chk("rnd_ready", cyc, int'(bus_if.alloc_ready_o), int'(exp_ready));
      chk("rnd_free_cnt", cyc, int'(bus_if.free_cnt_o), exp_cnt);
      if (exp_ready) begin
        off = 0;
        for (int s = 0; s < 4; s++) begin
          if (req[s]) begin
            chk("rnd_preg", cyc, int'(bus_if.alloc_preg_o[s]), fl[spec_n + off]);
            off++;
          end else begin
            chk("rnd_preg_idle", cyc, int'(bus_if.alloc_preg_o[s]), 0);
          end
        end
      end
      @(posedge clk); #1;

      if (exp_ready && k > 0) spec_n += k;
      c = pc({2'b0, cm});
      for (int j = 0; j < c; j++) released.push_back(fl.pop_front());
      spec_n -= c;
      if (rs) spec_n = 0;
      for (int j = 0; j < f; j++) fl.push_back(released.pop_front());
    end
    drive(4'b0, 2'b0, 2'b0, 6'd0, 6'd0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(4'b0, 2'b0, 2'b0, 6'd0, 6'd0, 1'b0);

    // rst rep req cm fr fp0 fp1 rs | ready p0 p1 p2 p3 cnt
    vecs.push_back(mk(1, 1, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 1,  0,  0,  0,  0, 63));
    vecs.push_back(mk(0, 1, 4'b1011, 2'b00, 2'b00, 0, 0, 0, 1,  1,  2,  0,  3, 63));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 1,  0,  0,  0,  0, 60));
    // exhaust
    vecs.push_back(mk(1, 15, 4'b1111, 2'b00, 2'b00, 0, 0, 0, 1, 57, 58, 59, 60, 7));
    vecs.push_back(mk(0, 1, 4'b1111, 2'b00, 2'b00, 0, 0, 0, 0, 61, 62, 63,  0, 3));
    vecs.push_back(mk(0, 1, 4'b0111, 2'b00, 2'b00, 0, 0, 0, 1, 61, 62, 63,  0, 3));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b11, 2'b00, 0, 0, 0, 1,  0,  0,  0,  0, 0));
    // free across the wrap
    vecs.push_back(mk(0, 1, 4'b0000, 2'b11, 2'b11, 5, 9, 0, 1,  0,  0,  0,  0, 0));
    vecs.push_back(mk(0, 1, 4'b0011, 2'b00, 2'b00, 0, 0, 0, 1,  5,  9,  0,  0, 2));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 1,  0,  0,  0,  0, 0));
    // restore with same-cycle commit
    vecs.push_back(mk(1, 2, 4'b1111, 2'b00, 2'b00, 0, 0, 0, 1,  5,  6,  7,  8, 59));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b11, 2'b00, 0, 0, 0, 1,  0,  0,  0,  0, 55));
    vecs.push_back(mk(0, 1, 4'b0001, 2'b01, 2'b00, 0, 0, 1, 0,  9,  0,  0,  0, 55));
    vecs.push_back(mk(0, 1, 4'b0001, 2'b00, 2'b00, 0, 0, 0, 1,  4,  0,  0,  0, 60));
    // same-cycle alloc and free at low count
    vecs.push_back(mk(1, 15, 4'b1111, 2'b00, 2'b00, 0, 0, 0, 1, 57, 58, 59, 60, 7));
    vecs.push_back(mk(0, 1, 4'b0001, 2'b11, 2'b00, 0, 0, 0, 1, 61,  0,  0,  0, 3));
    vecs.push_back(mk(0, 1, 4'b0011, 2'b11, 2'b11, 7, 8, 0, 1, 62, 63,  0,  0, 2));
    vecs.push_back(mk(0, 1, 4'b0011, 2'b00, 2'b00, 0, 0, 0, 1,  7,  8,  0,  0, 2));
    vecs.push_back(mk(0, 1, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 1,  0,  0,  0,  0, 0));

    foreach (vecs[i]) apply_row(vecs[i], i);

    random_phase(600);

`ifdef FREELIST_CHECK_EN
    chk("err_after_random", 0, int'(bus_if.err_o), 0);
    do_reset();
    chk("err_reset", 0, int'(bus_if.err_o), 0);
    drive(4'b0001, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    @(posedge clk); #1;
    drive(4'b0000, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    @(posedge clk); #1;
    drive(4'b0000, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    @(negedge clk);
    chk("err_legal", 0, int'(bus_if.err_o), 0);
    @(posedge clk); #1;
    drive(4'b0000, 2'b00, 2'b01, 6'd0, 6'd0, 1'b0);
    @(posedge clk); #1;
    drive(4'b0000, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("err_sticky", i, int'(bus_if.err_o), 1);
      @(posedge clk); #1;
    end
    do_reset();
    chk("err_cleared", 0, int'(bus_if.err_o), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
